lab04plus_timer_ctrl: RTL and testbench
=======================================

# lab04plus_timer_ctrl

Run-control block for the lab04plus stopwatch/countdown timer. Sits between the board switches (start, suspend, mode) and the 7-segment display path. Owns the 1 Hz tick divider, the run/pause/done state machine and a 4-digit BCD MM:SS count. The display driver consumes its `bcd`, `state` and `done` outputs unchanged.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per count step (1 s at 100 MHz); ≥2; bench overrides to 4.
- `PRESET`, default 16'h0130: countdown start value, valid MM:SS BCD (01:30).
- `clock_100MHZ`  in  1  sole clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level switch; a rising edge (after sync) starts a run.
- `suspend`  in  1  level switch; high pauses a run.
- `mode`  in  3  3'b001 count up, 3'b010 count down, other values idle.
- `bcd`  out  16  {min_tens, min_ones, sec_tens, sec_ones}, one BCD digit per nibble.
- `state`  out  3  current FSM state encoding.
- `running`  out  1  high when state is RUN.
- `done`  out  1  high when state is DONE.
- `tick`  out  1  one-cycle pulse on the cycle a count step is applied.

## Operation
- `start` and `suspend` each pass through a 2-flop synchronizer. Start edge = `start_s & ~start_s_d`.
- **IDLE**
  - On start edge with mode 001: mode latched, `bcd` ← 16'h0000, divider ← 0, go to RUN.
  - On start edge with mode 010: same, but `bcd` ← PRESET.
  - Any other mode: start edge ignored, stay in IDLE, `bcd` holds its value.
- **RUN**
  - Divider increments each cycle. `tick` = (state==RUN && div==TICK_DIV-1); div then wraps to 0.
  - On tick, up mode: `bcd` increments with carries. sec_ones 9→0 carries; sec_tens 5→0 carries; min_ones 9→0 carries; min_tens max 5.
  - On tick, down mode: `bcd` decrements with the mirrored borrows.
  - Up mode: when `bcd` becomes 16'h5959, go to DONE on the same edge.
  - Down mode: when `bcd` becomes 16'h0000, go to DONE on the same edge.
  - If synced suspend==1: go to PAUSE. Suspend takes priority over a same-cycle tick, so no step is applied.
- **PAUSE**
  - Divider and `bcd` frozen, `tick`=0.
  - Synced suspend==0: return to RUN, divider resumes from its held value.
- **DONE**
  - `bcd` frozen, `tick`=0.
  - Synced start==0: go to IDLE; `bcd` keeps the final value.
- Mode changes after the latch are ignored until the next IDLE start.
- Start edges in RUN, PAUSE and DONE are ignored.
- Reset (any state, mid-count included): state=IDLE, `bcd`=0, divider=0, synchronizers=0, latched mode=0. All outputs 0.

## Timing
- The start switch rising before edge k gives RUN after edge k+2; sync 2 edges, then edge detect plus transition on the third.
- First tick occurs TICK_DIV cycles after entering RUN. Ticks are then exactly TICK_DIV cycles apart, excluding PAUSE cycles.
- `bcd` updates on the rising edge that ends the tick cycle. The new value is visible the cycle after `tick` is high.
- `running`/`done` are decoded from the state register: registered, no combinational path from inputs.
- Suspend latency to PAUSE is 3 edges, same as start. No tick can be lost or duplicated across a pause.

## Structure
- Package `lab04plus_pkg`:
  - `typedef enum logic [2:0] {ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3} timer_state_t`.
  - Constants `MODE_UP=3'b001`, `MODE_DOWN=3'b010`, `BCD_MAX=16'h5959`.
- Sub-module `bcd_mmss_counter`: synchronous load/inc/dec of the 16-bit MM:SS value, with an `at_limit` output. Owned and instantiated once by the controller.
- Divider, synchronizers and FSM stay in `lab04plus_timer_ctrl`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold reset_n=0 mid-RUN (bcd=16'h0007) → outputs immediately 0, state=ST_IDLE. After release, stays idle until a new start edge.
- Count up: mode=001, raise start → RUN 3 edges later. Ticks every 4 cycles; bcd=16'h0004 after 4 ticks, 16'h0100 after 60 ticks.
- Count down: PRESET=16'h0102, mode=010 → bcd=16'h0059 after 3 ticks. At 62 ticks bcd=16'h0000, done=1, no further ticks. Lowering start → ST_IDLE with bcd still 16'h0000.
- Pause: count up, suspend=1 after 10 ticks, held 100 cycles → bcd stays 16'h0010, tick=0. On release, next tick after the residual divider count only.
- Up limit: run 3599 ticks → bcd=16'h5959, state=ST_DONE; extra cycles leave it unchanged.
- Illegal/changed mode: mode=000 + start edge → stays ST_IDLE. Mode switched 001→010 mid-RUN → keeps counting up.

Source files
------------

// File: rtl/lab04plus_pkg.sv
// Shared types and constants for the lab04plus stopwatch/countdown timer.
// Used by the run-control FSM and by the MM:SS BCD counter.
package lab04plus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } timer_state_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } bcd_op_t;

    localparam logic [2:0]  MODE_UP   = 3'b001;
    localparam logic [2:0]  MODE_DOWN = 3'b010;
    localparam logic [15:0] BCD_MAX   = 16'h5959;
    localparam logic [15:0] BCD_MIN   = 16'h0000;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit MM:SS BCD register with load, increment and decrement.
// at_limit flags that the step requested this cycle lands on 59:59 (up) or 00:00 (down).
module bcd_mmss_counter
    import lab04plus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  bcd_op_t     op,
    input  logic [15:0] load_value,
    output logic [15:0] value,
    output logic        at_limit
);

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic [3:0]  sec_ones;
    logic [3:0]  sec_tens;
    logic [3:0]  min_ones;
    logic [3:0]  min_tens;

    always_comb begin
        value_d  = value_q;
        min_tens = value_q[15:12];
        min_ones = value_q[11:8];
        sec_tens = value_q[7:4];
        sec_ones = value_q[3:0];
        case (op)
            OP_LOAD: value_d = load_value;
            OP_INC: begin
                // Each digit only moves when every lower digit wrapped.
                if (sec_ones != 4'd9) begin
                    sec_ones = sec_ones + 4'd1;
                end else begin
                    sec_ones = 4'd0;
                    if (sec_tens != 4'd5) begin
                        sec_tens = sec_tens + 4'd1;
                    end else begin
                        sec_tens = 4'd0;
                        if (min_ones != 4'd9) begin
                            min_ones = min_ones + 4'd1;
                        end else begin
                            min_ones = 4'd0;
                            min_tens = (min_tens != 4'd5) ? min_tens + 4'd1 : 4'd0;
                        end
                    end
                end
                value_d = {min_tens, min_ones, sec_tens, sec_ones};
            end
            OP_DEC: begin
                if (sec_ones != 4'd0) begin
                    sec_ones = sec_ones - 4'd1;
                end else begin
                    sec_ones = 4'd9;
                    if (sec_tens != 4'd0) begin
                        sec_tens = sec_tens - 4'd1;
                    end else begin
                        sec_tens = 4'd5;
                        if (min_ones != 4'd0) begin
                            min_ones = min_ones - 4'd1;
                        end else begin
                            min_ones = 4'd9;
                            min_tens = (min_tens != 4'd0) ? min_tens - 4'd1 : 4'd5;
                        end
                    end
                end
                value_d = {min_tens, min_ones, sec_tens, sec_ones};
            end
            default: value_d = value_q;
        endcase
    end

    always_comb begin
        at_limit = ((op == OP_INC) && (value_d == BCD_MAX)) ||
                   ((op == OP_DEC) && (value_d == BCD_MIN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/lab04plus_timer_ctrl.sv
// Run-control for the lab04plus timer: input synchronizers, count-step divider,
// IDLE/RUN/PAUSE/DONE state machine and the MM:SS counter it drives.
module lab04plus_timer_ctrl
    import lab04plus_pkg::*;
#(
    parameter int          TICK_DIV = 100_000_000,
    parameter logic [15:0] PRESET   = 16'h0130
) (
    input  logic        clock_100MHZ,
    input  logic        reset_n,
    input  logic        start,
    input  logic        suspend,
    input  logic [2:0]  mode,
    output logic [15:0] bcd,
    output logic [2:0]  state,
    output logic        running,
    output logic        done,
    output logic        tick
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    timer_state_t     state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       mode_q, mode_d;
    logic             start_meta_q, start_meta_d;
    logic             start_sync_q, start_sync_d;
    logic             start_prev_q, start_prev_d;
    logic             susp_meta_q, susp_meta_d;
    logic             susp_sync_q, susp_sync_d;

    logic             start_edge;
    logic             valid_start;
    bcd_op_t          cnt_op;
    logic [15:0]      cnt_load;
    logic             at_limit;

    assign start_edge  = start_sync_q & ~start_prev_q;
    assign valid_start = start_edge && ((mode == MODE_UP) || (mode == MODE_DOWN));

    always_comb begin
        start_meta_d = start;
        start_sync_d = start_meta_q;
        start_prev_d = start_sync_q;
        susp_meta_d  = suspend;
        susp_sync_d  = susp_meta_q;
    end

    always_ff @(posedge clock_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (valid_start) state_d = ST_RUN;
            ST_RUN: begin
                if (susp_sync_q) begin
                    state_d = ST_PAUSE;
                end else if (tick && at_limit) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: if (!susp_sync_q) state_d = ST_RUN;
            ST_DONE:  if (!start_sync_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Suspend wins over a same-cycle tick: the divider holds so the step is deferred, not lost.
    always_comb begin
        running  = 1'b0;
        done     = 1'b0;
        tick     = 1'b0;
        cnt_op   = OP_HOLD;
        cnt_load = '0;
        div_d    = div_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_start) begin
                    mode_d   = mode;
                    div_d    = '0;
                    cnt_op   = OP_LOAD;
                    cnt_load = (mode == MODE_UP) ? BCD_MIN : PRESET;
                end
            end
            ST_RUN: begin
                running = 1'b1;
                if (!susp_sync_q) begin
                    if (div_q == DIV_LAST) begin
                        tick   = 1'b1;
                        div_d  = '0;
                        cnt_op = (mode_q == MODE_UP) ? OP_INC : OP_DEC;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            div_q        <= '0;
            mode_q       <= '0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            susp_meta_q  <= 1'b0;
            susp_sync_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            mode_q       <= mode_d;
            start_meta_q <= start_meta_d;
            start_sync_q <= start_sync_d;
            start_prev_q <= start_prev_d;
            susp_meta_q  <= susp_meta_d;
            susp_sync_q  <= susp_sync_d;
        end
    end

    bcd_mmss_counter u_counter (
        .clk        (clock_100MHZ),
        .rst_n      (reset_n),
        .op         (cnt_op),
        .load_value (cnt_load),
        .value      (bcd),
        .at_limit   (at_limit)
    );

    assign state = state_q;

endmodule

// File: tb/tb_lab04plus_timer_ctrl.sv
// Self-checking bench for lab04plus_timer_ctrl: directed table, corner sequences and
// random switch activity, all compared against a seconds-based reference model.
module tb_lab04plus_timer_ctrl;

    localparam int          TICK_DIV = 4;
    localparam logic [15:0] PRESET   = 16'h0102;

    logic        clock_100MHZ = 1'b0;
    logic        reset_n      = 1'b0;
    logic        start        = 1'b0;
    logic        suspend      = 1'b0;
    logic [2:0]  mode         = 3'd0;
    logic [15:0] bcd;
    logic [2:0]  state;
    logic        running;
    logic        done;
    logic        tick;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    lab04plus_timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .PRESET   (PRESET)
    ) dut (
        .clock_100MHZ (clock_100MHZ),
        .reset_n      (reset_n),
        .start        (start),
        .suspend      (suspend),
        .mode         (mode),
        .bcd          (bcd),
        .state        (state),
        .running      (running),
        .done         (done),
        .tick         (tick)
    );

    always #5 clock_100MHZ = ~clock_100MHZ;

    function automatic int bcd_to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Reference model: time kept as whole seconds, phase counts run cycles since the last step.
    int m_state = 0;
    int m_secs  = 0;
    int m_phase = 0;
    bit m_up    = 1'b0;
    bit m_st_meta = 1'b0, m_st_sync = 1'b0, m_st_prev = 1'b0;
    bit m_su_meta = 1'b0, m_su_sync = 1'b0;

    always @(posedge clock_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_secs = 0; m_phase = 0; m_up = 1'b0;
            m_st_meta = 1'b0; m_st_sync = 1'b0; m_st_prev = 1'b0;
            m_su_meta = 1'b0; m_su_sync = 1'b0;
        end else begin
            case (m_state)
                0: if (m_st_sync && !m_st_prev && (mode == 3'd1 || mode == 3'd2)) begin
                    m_up    = (mode == 3'd1);
                    m_secs  = m_up ? 0 : bcd_to_secs(PRESET);
                    m_phase = 0;
                    m_state = 1;
                end
                1: if (m_su_sync) begin
                    m_state = 2;
                end else if (m_phase == TICK_DIV - 1) begin
                    m_phase = 0;
                    m_secs  = m_secs + (m_up ? 1 : -1);
                    if ((m_up && m_secs == 3599) || (!m_up && m_secs == 0)) m_state = 3;
                end else begin
                    m_phase = m_phase + 1;
                end
                2: if (!m_su_sync) m_state = 1;
                3: if (!m_st_sync) m_state = 0;
                default: m_state = 0;
            endcase
            m_st_prev = m_st_sync; m_st_sync = m_st_meta; m_st_meta = start;
            m_su_sync = m_su_meta; m_su_meta = suspend;
        end
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    always @(negedge clock_100MHZ) begin
        if (chk_en) begin
            check_output("model_bcd",     bcd,           secs_to_bcd(m_secs));
            check_output("model_state",   16'(state),    16'(m_state));
            check_output("model_running", 16'(running),  16'(m_state == 1));
            check_output("model_done",    16'(done),     16'(m_state == 3));
            check_output("model_tick",    16'(tick),
                         16'(m_state == 1 && !m_su_sync && m_phase == TICK_DIV - 1));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_100MHZ);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] m);
        reset_n = 1'b0; start = 1'b0; suspend = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        mode = m;
        cycles(1);
        start = 1'b1;
    endtask

    task automatic check_state(input string name, input logic [15:0] exp_bcd, input int exp_state);
        check_output({name, "_bcd"},     bcd,          exp_bcd);
        check_output({name, "_state"},   16'(state),   16'(exp_state));
        check_output({name, "_running"}, 16'(running), 16'(exp_state == 1));
        check_output({name, "_done"},    16'(done),    16'(exp_state == 3));
    endtask

    typedef struct {
        logic [2:0]  mode;
        int          n_ticks;
        logic [15:0] exp_bcd;
        int          exp_state;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{3'b001,  4, 16'h0004, 1};
        vecs[1] = '{3'b001, 60, 16'h0100, 1};
        vecs[2] = '{3'b001, 75, 16'h0115, 1};
        vecs[3] = '{3'b010,  3, 16'h0059, 1};
        vecs[4] = '{3'b010, 30, 16'h0032, 1};
        vecs[5] = '{3'b010, 62, 16'h0000, 3};
        vecs[6] = '{3'b000,  5, 16'h0000, 0};
        vecs[7] = '{3'b011,  5, 16'h0000, 0};

        reset_n = 1'b0;
        cycles(3);
        check_state("reset", 16'h0000, 0);
        check_output("reset_tick", 16'(tick), 16'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cycles(2);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].mode);
            cycles(3 + TICK_DIV * vecs[i].n_ticks);
            check_state($sformatf("vec%0d", i), vecs[i].exp_bcd, vecs[i].exp_state);
            start = 1'b0;
        end

        // Pause after 10 ticks: value frozen, then exactly the residual divider count on resume.
        apply_stimulus(3'b001);
        cycles(3 + TICK_DIV * 10);
        check_state("pause_entry", 16'h0010, 1);
        suspend = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            check_output("pause_bcd", bcd, 16'h0010);
            check_output("pause_tick", 16'(tick), 16'h0);
        end
        check_state("pause_hold", 16'h0010, 2);
        suspend = 1'b0;
        cycles(4);
        check_output("resume_tick", 16'(tick), 16'h1);
        check_output("resume_bcd_before", bcd, 16'h0010);
        cycles(1);
        check_state("resume_after", 16'h0011, 1);

        // Reset mid-run clears outputs without a clock edge.
        apply_stimulus(3'b001);
        cycles(3 + TICK_DIV * 7);
        check_state("prereset", 16'h0007, 1);
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        check_state("async_reset", 16'h0000, 0);
        check_output("async_reset_tick", 16'(tick), 16'h0);
        cycles(2);
        reset_n = 1'b1;
        cycles(10);
        check_state("post_reset_idle", 16'h0000, 0);

        // Countdown to zero, held in DONE, then back to IDLE keeping 00:00.
        apply_stimulus(3'b010);
        cycles(3 + TICK_DIV * 62);
        check_state("down_done", 16'h0000, 3);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check_output("down_done_tick", 16'(tick), 16'h0);
        end
        check_state("down_done_hold", 16'h0000, 3);
        start = 1'b0;
        cycles(3);
        check_state("down_idle", 16'h0000, 0);

        // Mode change mid-run is ignored.
        apply_stimulus(3'b001);
        cycles(3 + TICK_DIV * 5);
        mode = 3'b010;
        cycles(TICK_DIV * 5);
        check_state("mode_change", 16'h0010, 1);

        // Count up to the 59:59 limit.
        apply_stimulus(3'b001);
        cycles(3 + TICK_DIV * 3599);
        check_state("up_limit", 16'h5959, 3);
        cycles(50);
        check_state("up_limit_hold", 16'h5959, 3);
        start = 1'b0;
        cycles(3);
        check_state("up_limit_idle", 16'h5959, 0);

        // Random switch activity against the model.
        apply_stimulus(3'b001);
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 149) == 0) start = ~start;
            if ($urandom_range(0, 59) == 0) suspend = ~suspend;
            if ($urandom_range(0, 99) == 0) begin
                if ($urandom_range(0, 3) == 0) mode = 3'($urandom_range(0, 7));
                else mode = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b010;
            end
            cycles(1);
        end
        reset_n = 1'b1;
        cycles(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
